// File: rtl/tts_pkg.sv
// ============================================================================
// tts_pkg: shared state encoding and table-width helper for the scanner.
// Rev 1.0
// ============================================================================
`default_nettype none

package tts_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SAMPLE = 3'd2,
    EMIT   = 3'd3,
    DONE   = 3'd4
  } tts_state_t;

  function automatic int TBL_W(input int n_vars);
    return 1 << n_vars;
  endfunction

endpackage

`default_nettype wire

// File: rtl/truth_table_scanner_settle_timer.sv
// ============================================================================
// settle_timer: loads SETTLE on i_load, counts down, flags when settled.
// Rev 1.0
// ============================================================================
`default_nettype none

module settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  output logic o_expired
);

  localparam int               CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] C_INIT = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] r_cnt;

  // The load cycle itself is the first settle cycle, hence SETTLE-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= C_INIT;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/truth_table_scanner.sv
// ============================================================================
// truth_table_scanner: sweeps all FUT input codes, records the truth table
// and streams minterm indices over valid/ready.  Rev 1.0
// ============================================================================
`default_nettype none

module truth_table_scanner
  import tts_pkg::*;
#(
  parameter int N_VARS = 4,
  parameter int SETTLE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic [N_VARS-1:0]         vars_out,
  input  logic                      f_in,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [N_VARS-1:0]         m_index,
  output logic                      busy,
  output logic                      done,
  output logic [TBL_W(N_VARS)-1:0]  truth_tbl,
  output logic [N_VARS:0]           m_count
);

  localparam int                C_TBL_W = TBL_W(N_VARS);
  localparam logic [N_VARS-1:0] C_LAST  = {N_VARS{1'b1}};

  tts_state_t         r_state;
  tts_state_t         w_next;
  logic [N_VARS-1:0]  r_idx;
  logic [C_TBL_W-1:0] r_tbl;
  logic [N_VARS:0]    r_cnt;
  logic               r_m_valid;
  logic [N_VARS-1:0]  r_m_index;
  logic               r_busy;
  logic               r_done;
  logic               w_load;
  logic               w_adv;
  logic               w_last;
  logic               w_expired;

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .o_expired (w_expired)
  );

  assign w_last = (r_idx == C_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_adv  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = DRIVE;
          w_load = 1'b1;
        end
      end
      DRIVE:  if (w_expired) w_next = SAMPLE;
      SAMPLE: if (f_in) w_next = EMIT; else w_adv = 1'b1;
      EMIT:   if (r_m_valid && m_ready) w_adv = 1'b1;
      DONE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
    // End of sweep is a compare on the last code, never a counter wrap.
    if (w_adv) begin
      if (w_last) begin
        w_next = DONE;
      end else begin
        w_next = DRIVE;
        w_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx     <= '0;
      r_tbl     <= '0;
      r_cnt     <= '0;
      r_m_valid <= 1'b0;
      r_m_index <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_busy <= (w_next == DRIVE) || (w_next == SAMPLE) || (w_next == EMIT);
      r_done <= (r_state == DONE);
      if (r_state == IDLE && start) begin
        r_idx <= '0;
        r_tbl <= '0;
        r_cnt <= '0;
      end
      if (r_state == SAMPLE) begin
        r_tbl[r_idx] <= f_in;
        if (f_in) begin
          r_m_valid <= 1'b1;
          r_m_index <= r_idx;
          r_cnt     <= r_cnt + 1'b1;
        end
      end
      if (r_state == EMIT && m_ready) begin
        r_m_valid <= 1'b0;
      end
      if (w_adv && !w_last) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign vars_out  = r_idx;
  assign m_valid   = r_m_valid;
  assign m_index   = r_m_index;
  assign busy      = r_busy;
  assign done      = r_done;
  assign truth_tbl = r_tbl;
  assign m_count   = r_cnt;

endmodule

`default_nettype wire
